fetch_stage: RTL and testbench



---
 rtl/fetch_stage_if.sv | 21 ++
 rtl/fetch_stage.sv | 99 +++++++++
 tb/tb_fetch_stage.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory request/response bundle for the fetch stage
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS fetch stage: PC register, imem request, IF/ID register, fetch counter
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         StallF,
    input  logic         StallD,
    input  logic         PCSrcD,
    input  logic         JumpD,
    input  logic [31:0]  PCBranchD,
    input  logic [31:0]  PCJumpD,
    fetch_stage_if.master imem,
    output logic [31:0]  InstrD,
    output logic [31:0]  PCPlus4D,
    output logic         ValidD,
    output logic         FetchWaitF,
    output logic [31:0]  PCF,
    output logic [31:0]  FetchCount
);
    typedef enum logic [1:0] {BOOT, RUN, WAIT} fetchState_t;

    fetchState_t state, stateNext;
    logic        fetchDone;
    logic        redirect;
    logic [31:0] redirectTarget;
    logic [31:0] pcPlus4F;
    logic        loadD;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= BOOT;
        end else begin
            state <= stateNext;
        end
    end

    // RUN and WAIT differ only in bookkeeping; the request stays up in both.
    always_comb begin
        stateNext     = state;
        imem.imem_req = 1'b0;
        case (state)
            BOOT: begin
                stateNext = RUN;
            end
            RUN: begin
                imem.imem_req = 1'b1;
                if (!imem.imem_ready) stateNext = WAIT;
            end
            WAIT: begin
                imem.imem_req = 1'b1;
                if (imem.imem_ready) stateNext = RUN;
            end
            default: begin
                stateNext = BOOT;
            end
        endcase
    end

    assign fetchDone      = (state != BOOT) && imem.imem_ready;
    assign FetchWaitF     = !fetchDone;
    assign redirect       = (PCSrcD || JumpD) && !StallD;
    assign redirectTarget = (JumpD ? PCJumpD : PCBranchD) & 32'hFFFF_FFFC;
    assign pcPlus4F       = PCF + 32'd4;
    assign loadD          = !StallD && !redirect && fetchDone && !StallF;
    assign imem.imem_addr = PCF;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            PCF <= RESET_PC;
        end else if (!StallF) begin
            if (redirect) begin
                PCF <= redirectTarget;
            end else if (fetchDone) begin
                PCF <= pcPlus4F;
            end
        end
    end

    // Any non-load, non-stall cycle becomes a NOP bubble; PCPlus4D keeps its last value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            InstrD     <= 32'h0;
            PCPlus4D   <= 32'h0;
            ValidD     <= 1'b0;
            FetchCount <= 32'h0;
        end else if (!StallD) begin
            if (loadD) begin
                InstrD     <= imem.imem_rdata;
                PCPlus4D   <= pcPlus4F;
                ValidD     <= 1'b1;
                FetchCount <= FetchCount + 32'd1;
            end else begin
                InstrD <= 32'h0;
                ValidD <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized and directed bench for fetch_stage against a behavioural model
module tb_fetch_stage;
    logic        clk;
    logic        reset_n;
    logic        StallF, StallD, PCSrcD, JumpD;
    logic [31:0] PCBranchD, PCJumpD;
    logic [31:0] InstrD, PCPlus4D, PCF, FetchCount;
    logic        ValidD, FetchWaitF;

    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .StallF     (StallF),
        .StallD     (StallD),
        .PCSrcD     (PCSrcD),
        .JumpD      (JumpD),
        .PCBranchD  (PCBranchD),
        .PCJumpD    (PCJumpD),
        .imem       (bus.master),
        .InstrD     (InstrD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD),
        .FetchWaitF (FetchWaitF),
        .PCF        (PCF),
        .FetchCount (FetchCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passCnt = 0;
    int totalCnt = 0;

    // Model: only "has the first post-reset edge happened" matters to the outputs.
    bit          mBooted;
    logic [31:0] mPc, mInstr, mPc4, mCount;
    bit          mValid;
    logic [31:0] salt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    endtask

    task automatic modelReset();
        mBooted = 0;
        mPc     = 32'h0;
        mInstr  = 32'h0;
        mPc4    = 32'h0;
        mValid  = 0;
        mCount  = 32'h0;
    endtask

    task automatic modelStep();
        bit          done, redir;
        logic [31:0] tgt, pc;
        done  = mBooted && bus.imem_ready;
        redir = (PCSrcD || JumpD) && !StallD;
        tgt   = (JumpD ? PCJumpD : PCBranchD) & ~32'd3;
        pc    = mPc;
        if (!StallD) begin
            if (!redir && done && !StallF) begin
                mInstr = bus.imem_rdata;
                mPc4   = pc + 32'd4;
                mValid = 1;
                mCount = mCount + 32'd1;
            end else begin
                mInstr = 32'h0;
                mValid = 0;
            end
        end
        if (!StallF) begin
            if (redir) mPc = tgt;
            else if (done) mPc = pc + 32'd4;
        end
        mBooted = 1;
    endtask

    task automatic checkAll();
        chk("imem_req",   {31'b0, bus.imem_req}, {31'b0, mBooted});
        chk("imem_addr",  bus.imem_addr, mPc);
        chk("PCF",        PCF, mPc);
        chk("InstrD",     InstrD, mInstr);
        chk("PCPlus4D",   PCPlus4D, mPc4);
        chk("ValidD",     {31'b0, ValidD}, {31'b0, mValid});
        chk("FetchWaitF", {31'b0, FetchWaitF}, {31'b0, !(mBooted && bus.imem_ready)});
        chk("FetchCount", FetchCount, mCount);
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic cycle(input bit sf, input bit sd, input bit ps, input bit jp,
                         input logic [31:0] br, input logic [31:0] jt, input bit rdy);
        StallF = sf; StallD = sd; PCSrcD = ps; JumpD = jp;
        PCBranchD = br; PCJumpD = jt;
        bus.imem_ready = rdy;
        bus.imem_rdata = rdy ? (bus.imem_addr ^ salt) : $urandom;
        #1;
        checkAll();
        @(posedge clk);
        modelStep();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 32'h0, 32'h0, 1);
    endtask

    task automatic resetPulse();
        #2 reset_n = 1'b0;
        #1;
        modelReset();
        chk("rst_PCF",        PCF, 32'h0);
        chk("rst_InstrD",     InstrD, 32'h0);
        chk("rst_FetchCount", FetchCount, 32'h0);
        chk("rst_imem_req",   {31'b0, bus.imem_req}, 32'h0);
        chk("rst_FetchWaitF", {31'b0, FetchWaitF}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    logic [31:0] holdPc, holdInstr, holdCount;

    initial begin
        reset_n = 1'b0;
        StallF = 0; StallD = 0; PCSrcD = 0; JumpD = 0;
        PCBranchD = 0; PCJumpD = 0;
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'h0;
        salt = 32'h0;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        chk("reset_PCF",        PCF, 32'h0);
        chk("reset_imem_req",   {31'b0, bus.imem_req}, 32'h0);
        chk("reset_FetchWaitF", {31'b0, FetchWaitF}, 32'h1);
        chk("reset_ValidD",     {31'b0, ValidD}, 32'h0);
        reset_n = 1'b1;

        // Zero-wait start-up: 0x0, 0x4 appear from the third cycle.
        run(2);
        chk("first_InstrD", InstrD, 32'h0);
        chk("first_ValidD", {31'b0, ValidD}, 32'h1);
        run(1);
        chk("second_InstrD", InstrD, 32'h4);
        chk("wait_startPC", PCF, 32'h8);

        // Two wait cycles at PCF=0x8.
        cycle(0, 0, 0, 0, 0, 0, 0);
        chk("wait1_PCF", PCF, 32'h8);
        cycle(0, 0, 0, 0, 0, 0, 0);
        chk("wait2_PCF",    PCF, 32'h8);
        chk("wait2_ValidD", {31'b0, ValidD}, 32'h0);
        run(1);
        chk("after_wait_InstrD", InstrD, 32'h8);
        chk("after_wait_count",  FetchCount, 32'h3);

        // Branch at PCF=0x10.
        run(1);
        chk("pre_branch_PCF", PCF, 32'h10);
        cycle(0, 0, 1, 0, 32'h40, 32'h0, 1);
        chk("branch_PCF",    PCF, 32'h40);
        chk("branch_bubble", {31'b0, ValidD}, 32'h0);
        run(1);
        chk("branch_InstrD", InstrD, 32'h40);

        // Jump beats branch.
        cycle(0, 0, 1, 1, 32'h80, 32'h100, 1);
        chk("jump_over_branch", PCF, 32'h100);
        run(2);

        // Full stall with an ignored redirect.
        holdPc = PCF; holdInstr = InstrD; holdCount = FetchCount;
        cycle(1, 1, 0, 0, 0, 0, 1);
        cycle(1, 1, 1, 0, 32'h200, 0, 1);
        cycle(1, 1, 0, 0, 0, 0, 0);
        chk("stall_PCF",    PCF, holdPc);
        chk("stall_InstrD", InstrD, holdInstr);
        chk("stall_count",  FetchCount, holdCount);

        // StallF only: PC holds, decode gets a bubble.
        cycle(1, 0, 0, 0, 0, 0, 1);
        chk("stallF_PCF",    PCF, holdPc);
        chk("stallF_bubble", {31'b0, ValidD}, 32'h0);

        // Misaligned target and PC wrap.
        cycle(0, 0, 0, 1, 0, 32'h43, 1);
        chk("align_PCF", PCF, 32'h40);
        cycle(0, 0, 1, 0, 32'hFFFF_FFFC, 0, 1);
        run(1);
        chk("wrap_PCF",    PCF, 32'h0);
        chk("wrap_InstrD", InstrD, 32'hFFFF_FFFC);
        chk("wrap_PC4",    PCPlus4D, 32'h0);

        // Redirect while waiting: new address presented, still waiting.
        cycle(0, 0, 1, 0, 32'h300, 0, 0);
        chk("wait_redirect_PCF", PCF, 32'h300);
        run(1);

        resetPulse();

        // Randomized traffic with an occasional mid-stream reset.
        salt = $urandom;
        for (int i = 0; i < 600; i++) begin
            if (i == 300) resetPulse();
            cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 15) == 0),
                  $urandom, $urandom, ($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
